// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: one valid/ready command in, one AXI4-Lite read or write
// out, one response back. A response timeout lets the requester recover from a hung slave.
`timescale 1ns/1ps

module axi_lite_cmd_master #(
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  aclk,
  input  logic                  aresetn,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_wstrb,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,

  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RSP} state_t;

  localparam int unsigned     CNT_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic [CNT_W-1:0]      tmo_cnt;
  logic                  tmo_hit;
  logic                  busy;
  logic                  xfer_done;
  logic                  aw_done;
  logic                  w_done;

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = wstrb_q;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;

  assign busy      = (state == WADDR) || (state == WRESP) || (state == RADDR) || (state == RDATA);
  // The edge on which the counter would reach TIMEOUT_CYCLES is the abort edge.
  assign tmo_hit   = (TIMEOUT_CYCLES != 0) && busy && (tmo_cnt + 1'b1 == TIMEOUT_VAL);
  assign xfer_done = ((state == WRESP) && m_axi_bvalid && m_axi_bready) ||
                     ((state == RDATA) && m_axi_rvalid && m_axi_rready);
  assign aw_done   = !m_axi_awvalid || m_axi_awready;
  assign w_done    = !m_axi_wvalid  || m_axi_wready;

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      tmo_cnt       <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
      rsp_timeout   <= 1'b0;
    end else begin
      if (busy) tmo_cnt <= tmo_cnt + 1'b1;

      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            tmo_cnt   <= '0;
            if (cmd_write) begin
              state         <= WADDR;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
            end else begin
              state         <= RADDR;
              m_axi_arvalid <= 1'b1;
            end
          end
        end
        WADDR: begin
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            state        <= WRESP;
            m_axi_bready <= 1'b1;
          end
        end
        WRESP: begin
          if (m_axi_bvalid) begin
            state        <= RSP;
            m_axi_bready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_resp     <= m_axi_bresp;
            rsp_rdata    <= '0;
            rsp_timeout  <= 1'b0;
          end
        end
        RADDR: begin
          if (m_axi_arready) begin
            state         <= RDATA;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
          end
        end
        RDATA: begin
          if (m_axi_rvalid) begin
            state        <= RSP;
            m_axi_rready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_resp     <= m_axi_rresp;
            rsp_rdata    <= m_axi_rdata;
            rsp_timeout  <= 1'b0;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // NOTE: this later assignment overrides the per-state ones above, so the abort wins
      // over partial progress while a completing transfer (xfer_done) still wins over the abort.
      if (tmo_hit && !xfer_done) begin
        state         <= RSP;
        m_axi_awvalid <= 1'b0;
        m_axi_wvalid  <= 1'b0;
        m_axi_bready  <= 1'b0;
        m_axi_arvalid <= 1'b0;
        m_axi_rready  <= 1'b0;
        rsp_valid     <= 1'b1;
        rsp_resp      <= 2'b10;
        rsp_rdata     <= '0;
        rsp_timeout   <= 1'b1;
      end
    end
  end

endmodule
